// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU data-port bridges: FSM state enum,
// sram-like size codes and byte-enable decode helpers.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bridge_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic [1:0] wen_to_size(
    input logic [3:0] wen
  );
    logic [1:0] s;
    case (wen)
      4'b0001, 4'b0010,
      4'b0100, 4'b1000: s = SIZE_BYTE;
      4'b0011, 4'b1100: s = SIZE_HALF;
      default:          s = SIZE_WORD;
    endcase
    return s;
  endfunction

  function automatic logic wen_legal(
    input logic [3:0] wen
  );
    logic ok;
    case (wen)
      4'b0000, 4'b0001, 4'b0010,
      4'b0100, 4'b1000, 4'b0011,
      4'b1100, 4'b1111: ok = 1'b1;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_sramlike_bridge.sv
// CPU single-cycle data port -> sram-like bus (req/addr_ok/data_ok).
// Ports: clk, resetn; cpu_en/wen/addr/wdata in, cpu_rdata/cpu_stall out;
// bus req/wr/size/addr/wdata out, addr_ok/data_ok/rdata in.
// Option: DATA_BRIDGE_RDATA_BYPASS_EN drops DONE, returns rdata on data_ok.
module data_sramlike_bridge
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata
);

  bridge_state_e state, state_nx;
  logic [DATA_W-1:0] rdata_q;
  logic              rd_done;

  // data_ok counts only in WAIT, which also masks the accept cycle
  assign rd_done = (state == WAIT) && data_ok;

  assign wr    = |cpu_wen;
  assign size  = wen_to_size(cpu_wen);
  assign addr  = cpu_addr;
  assign wdata = cpu_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (rd_done) rdata_q <= rdata;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (cpu_en)
              state_nx = addr_ok ? WAIT : REQ;
      REQ:  if (addr_ok) state_nx = WAIT;
`ifdef DATA_BRIDGE_RDATA_BYPASS_EN
      WAIT: if (data_ok) state_nx = IDLE;
`else
      WAIT: if (data_ok) state_nx = DONE;
`endif
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs are gated with resetn so they drop as soon as reset asserts
  always_comb begin
    req       = 1'b0;
    cpu_stall = 1'b0;
    cpu_rdata = rdata_q;
    unique case (state)
      IDLE: begin
        req       = cpu_en;
        cpu_stall = cpu_en;
      end
      REQ: begin
        req       = 1'b1;
        cpu_stall = cpu_en;
      end
      WAIT: begin
`ifdef DATA_BRIDGE_RDATA_BYPASS_EN
        cpu_stall = cpu_en && !data_ok;
        if (data_ok) cpu_rdata = rdata;
`else
        cpu_stall = cpu_en;
`endif
      end
      DONE: cpu_stall = 1'b0;
      default: ;
    endcase
    if (!resetn) begin
      req       = 1'b0;
      cpu_stall = 1'b0;
      cpu_rdata = '0;
    end
  end

`ifndef SYNTHESIS
  a_wen_legal: assert property (
    @(posedge clk) disable iff (!resetn)
    cpu_en |-> wen_legal(cpu_wen)
  );
`endif

endmodule

// File: tb/tb_data_sramlike_bridge.sv
// Directed bench for data_sramlike_bridge with a tiny bus responder.
// Expected values are hand-derived; summary on the last line.
module tb_data_sramlike_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] exp_rq;

`ifdef DATA_BRIDGE_RDATA_BYPASS_EN
  localparam int BASE_STALL = 1;
`else
  localparam int BASE_STALL = 2;
`endif

  always #5 clk = ~clk;

  data_sramlike_bridge dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_en    (cpu_en),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .req       (req),
    .wr        (wr),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
    .rdata     (rdata)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One CPU access; bus answers addr_ok at cycle adly and data_ok
  // ddly+1 cycles later. spur adds data_ok pulses before acceptance.
  task automatic access(
    input string       tag,
    input logic [3:0]  wen,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input int          adly,
    input int          ddly,
    input bit          spur,
    input logic [1:0]  exp_size
  );
    int acc;
    int stalls;
    int reqs;
    bit done;
    logic [31:0] rel;
    acc = -1; stalls = 0; reqs = 0;
    done = 1'b0; rel = '0;
    for (int k = 0; k < 40 && !done; k++) begin
      cpu_en    = 1'b1;
      cpu_wen   = wen;
      cpu_addr  = a;
      cpu_wdata = wd;
      addr_ok   = (acc < 0) && (k == adly);
      data_ok   = 1'b0;
      rdata     = 32'hBAD0_BAD0;
      if (acc < 0 && spur && k < adly) data_ok = 1'b1;
      if (acc >= 0 && k == acc + 1 + ddly) begin
        data_ok = 1'b1;
        rdata   = rd;
      end
      @(negedge clk);
      if (cpu_stall) stalls++;
      if (req) reqs++;
      if (k == 0) begin
        chk({tag, "_req0"}, {31'd0, req}, 32'd1);
        chk({tag, "_wr"}, {31'd0, wr}, {31'd0, |wen});
        chk({tag, "_size"}, {30'd0, size}, {30'd0, exp_size});
        chk({tag, "_addr"}, addr, a);
        chk({tag, "_wdata"}, wdata, wd);
      end
      if (acc < 0 && k == adly)
        chk({tag, "_req_aok"}, {31'd0, req}, 32'd1);
      if (cpu_stall)
        chk({tag, "_rhold"}, cpu_rdata, exp_rq);
      else begin
        done = 1'b1;
        rel  = cpu_rdata;
      end
      if (acc < 0 && k == adly) acc = k;
      @(posedge clk);
      #1;
    end
    addr_ok = 1'b0;
    data_ok = 1'b0;
    if (!done) begin
      chk({tag, "_timeout"}, 32'd1, 32'd0);
    end else begin
      chk({tag, "_stalls"}, stalls, adly + ddly + BASE_STALL);
      chk({tag, "_reqs"}, reqs, adly + 1);
      chk({tag, "_rdata"}, rel, rd);
    end
    exp_rq = rd;
  endtask

  task automatic idle_cycle(input bit dok);
    cpu_en  = 1'b0;
    addr_ok = 1'b0;
    data_ok = dok;
    rdata   = 32'h5555_AAAA;
    @(negedge clk);
    chk("idle_req", {31'd0, req}, 32'd0);
    chk("idle_stall", {31'd0, cpu_stall}, 32'd0);
    chk("idle_rdata", cpu_rdata, exp_rq);
    @(posedge clk);
    #1;
    data_ok = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; cpu_en = 1'b0; cpu_wen = '0;
    cpu_addr = '0; cpu_wdata = '0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    exp_rq = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    resetn = 1'b1;
    idle_cycle(1'b0);

    access("rd_min", 4'b0000, 32'h0000_1000, 32'd0,
           32'hDEAD_BEEF, 0, 0, 1'b0, 2'd2);
    idle_cycle(1'b0);
    access("wr_byte", 4'b0100, 32'h1FC0_0003, 32'h0000_AB00,
           32'h0000_0000, 0, 0, 1'b0, 2'd0);
    idle_cycle(1'b0);
    access("wr_half", 4'b1100, 32'h1FC0_0002, 32'h1234_0000,
           32'h0000_0011, 0, 0, 1'b0, 2'd1);
    idle_cycle(1'b0);
    access("rd_slow", 4'b0000, 32'h0000_2000, 32'd0,
           32'hCAFE_F00D, 3, 1, 1'b0, 2'd2);
    // no gap: next access starts in the IDLE right after release
    access("b2b_rd", 4'b0000, 32'h0000_3000, 32'd0,
           32'h0123_4567, 0, 0, 1'b0, 2'd2);
    access("b2b_wr", 4'b1111, 32'h0000_3004, 32'h89AB_CDEF,
           32'h7654_3210, 0, 0, 1'b0, 2'd2);
    idle_cycle(1'b1);
    access("spur", 4'b0000, 32'h0000_4000, 32'd0,
           32'h0F0F_0F0F, 2, 0, 1'b1, 2'd2);
    idle_cycle(1'b0);

    // reset while WAIT, then a fresh access
    cpu_en = 1'b1; cpu_wen = 4'b0000;
    cpu_addr = 32'h0000_5000; addr_ok = 1'b1;
    @(posedge clk);
    #1;
    addr_ok = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("rstw_req", {31'd0, req}, 32'd0);
    chk("rstw_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rstw_rdata", cpu_rdata, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_rq = '0;
    idle_cycle(1'b0);
    access("post_rst", 4'b0000, 32'h0000_5000, 32'd0,
           32'hA5A5_5A5A, 0, 0, 1'b0, 2'd2);
    idle_cycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
